// File: rtl/reg_wb_arbiter.sv
// ---------------------------------------------------------------------------------------------
// reg_wb_arbiter
//
// Shares the single register-file write port between two writeback requesters:
//   req0 = ALU result, req1 = load result.
// Each requester owns a one-entry holding buffer behind a valid/ready handshake. A round-robin
// arbiter drains the buffers into registered write-port outputs (wr/addr3/data3). The block
// also flags read-after-write hazards for two read addresses against every write that is still
// in flight: a valid holding entry, or the write currently being presented on the port.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   req0_valid/ready/addr/data     ALU writeback request channel
//   req1_valid/ready/addr/data     load writeback request channel
//   wr, addr3, data3               registered register-file write port
//   rd_addr1, rd_addr2             read addresses to check for pending writes
//   hazard1, hazard2               combinational hazard flags for rd_addr1/rd_addr2
// ---------------------------------------------------------------------------------------------
module reg_wb_arbiter #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter bit          SUPPRESS_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,

    output logic              wr,
    output logic [ADDR_W-1:0] addr3,
    output logic [DATA_W-1:0] data3,

    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hazard1,
    output logic              hazard2
);

    // Holding entries
    logic              hold0_v_q, hold0_v_d;
    logic [ADDR_W-1:0] hold0_addr_q, hold0_addr_d;
    logic [DATA_W-1:0] hold0_data_q, hold0_data_d;

    logic              hold1_v_q, hold1_v_d;
    logic [ADDR_W-1:0] hold1_addr_q, hold1_addr_d;
    logic [DATA_W-1:0] hold1_data_q, hold1_data_d;

    // Index of the most recently granted requester; reset to 1 so req0 wins the first tie.
    logic              last_grant_q, last_grant_d;

    // Registered write port
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr3_q, addr3_d;
    logic [DATA_W-1:0] data3_q, data3_d;

    logic              grant0, grant1;
    logic              accept0, accept1;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    // -----------------------------------------------------------------------------------------
    // Arbitration: decided purely from the holding flags, so it never looks at the incoming
    // valids and ready has no combinational path from valid.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        unique case ({hold1_v_q, hold0_v_q})
            2'b01:   grant0 = 1'b1;
            2'b10:   grant1 = 1'b1;
            2'b11: begin
                // Tie: the requester that was not granted last time goes first.
                if (last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // An entry can accept when it is empty or being drained this cycle.
    assign req0_ready = !hold0_v_q || grant0;
    assign req1_ready = !hold1_v_q || grant1;

    assign accept0 = req0_valid && req0_ready;
    assign accept1 = req1_valid && req1_ready;

    // -----------------------------------------------------------------------------------------
    // Holding entry next state. A refill in the same cycle as a grant keeps the entry valid,
    // which gives one transfer per cycle per requester.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        hold0_v_d    = hold0_v_q;
        hold0_addr_d = hold0_addr_q;
        hold0_data_d = hold0_data_q;
        if (grant0) begin
            hold0_v_d = 1'b0;
        end
        if (accept0) begin
            hold0_v_d    = 1'b1;
            hold0_addr_d = req0_addr;
            hold0_data_d = req0_data;
        end
    end

    always_comb begin
        hold1_v_d    = hold1_v_q;
        hold1_addr_d = hold1_addr_q;
        hold1_data_d = hold1_data_q;
        if (grant1) begin
            hold1_v_d = 1'b0;
        end
        if (accept1) begin
            hold1_v_d    = 1'b1;
            hold1_addr_d = req1_addr;
            hold1_data_d = req1_data;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Write port next state. The granted entry is always consumed; a grant to register 0 still
    // updates addr3/data3 but leaves wr low when suppression is enabled.
    // -----------------------------------------------------------------------------------------
    assign gnt_addr = grant1 ? hold1_addr_q : hold0_addr_q;
    assign gnt_data = grant1 ? hold1_data_q : hold0_data_q;

    always_comb begin
        wr_d    = 1'b0;
        addr3_d = addr3_q;
        data3_d = data3_q;
        if (grant0 || grant1) begin
            wr_d    = !(SUPPRESS_R0 && (gnt_addr == '0));
            addr3_d = gnt_addr;
            data3_d = gnt_data;
        end
    end

    // -----------------------------------------------------------------------------------------
    // State registers. Holding addr/data are reset too so nothing undefined can reach the
    // write port.
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold0_v_q    <= 1'b0;
            hold0_addr_q <= '0;
            hold0_data_q <= '0;
            hold1_v_q    <= 1'b0;
            hold1_addr_q <= '0;
            hold1_data_q <= '0;
            last_grant_q <= 1'b1;
            wr_q         <= 1'b0;
            addr3_q      <= '0;
            data3_q      <= '0;
        end else begin
            hold0_v_q    <= hold0_v_d;
            hold0_addr_q <= hold0_addr_d;
            hold0_data_q <= hold0_data_d;
            hold1_v_q    <= hold1_v_d;
            hold1_addr_q <= hold1_addr_d;
            hold1_data_q <= hold1_data_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            addr3_q      <= addr3_d;
            data3_q      <= data3_d;
        end
    end

    assign wr    = wr_q;
    assign addr3 = addr3_q;
    assign data3 = data3_q;

    // -----------------------------------------------------------------------------------------
    // Hazards: a read of a register that still has a write in flight. Register 0 never
    // hazards. The wr term covers the cycle in which the write port is driving but the
    // register file has not yet captured the value.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        hazard1 = (rd_addr1 != '0) &&
                  ((hold0_v_q && (hold0_addr_q == rd_addr1)) ||
                   (hold1_v_q && (hold1_addr_q == rd_addr1)) ||
                   (wr_q      && (addr3_q      == rd_addr1)));
        hazard2 = (rd_addr2 != '0) &&
                  ((hold0_v_q && (hold0_addr_q == rd_addr2)) ||
                   (hold1_v_q && (hold1_addr_q == rd_addr2)) ||
                   (wr_q      && (addr3_q      == rd_addr2)));
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_reg_wb_arbiter
//
// Directed bench for reg_wb_arbiter. A table of per-cycle records drives the inputs and holds
// the expected outputs for single writes, contention, register-0 suppression, hazards and a
// mid-flight reset. A hand-written saturation sequence then streams 16 writes per requester
// and checks ready alternation and write ordering against a scoreboard.
// ---------------------------------------------------------------------------------------------
module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        wr;
    logic [4:0]  addr3;
    logic [31:0] data3;
    logic [4:0]  rd_addr1, rd_addr2;
    logic        hazard1, hazard2;

    reg_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .wr         (wr),
        .addr3      (addr3),
        .data3      (data3),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .hazard1    (hazard1),
        .hazard2    (hazard2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One record per cycle: inputs applied before the edge, outputs expected in that cycle.
    typedef struct packed {
        logic        rst_n;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        rdy0;
        logic        rdy1;
        logic        wr;
        logic [4:0]  a3;
        logic [31:0] d3;
        logic        hz1;
        logic        hz2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic v0, input logic [4:0] a0,
                       input logic [31:0] d0, input logic v1, input logic [4:0] a1,
                       input logic [31:0] d1, input logic [4:0] r1, input logic [4:0] r2,
                       input logic rdy0, input logic rdy1, input logic ewr,
                       input logic [4:0] a3, input logic [31:0] d3,
                       input logic hz1, input logic hz2);
        vec_t v;
        v = '{rst, v0, a0, d0, v1, a1, d1, r1, r2, rdy0, rdy1, ewr, a3, d3, hz1, hz2};
        vecs.push_back(v);
    endtask

    // Cycle with no requests.
    task automatic idle(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                        input logic rdy0, input logic rdy1, input logic ewr,
                        input logic [4:0] a3, input logic [31:0] d3,
                        input logic hz1, input logic hz2);
        add(rst, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, r1, r2,
            rdy0, rdy1, ewr, a3, d3, hz1, hz2);
    endtask

    // Scoreboard for the saturation sequence: {addr, data}
    logic [36:0] q0[$];
    logic [36:0] q1[$];
    logic [36:0] exp_item;
    int          sent0, sent1, got0, got1;
    logic        acc0, acc1;
    vec_t        v;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        rd_addr1   = '0;   rd_addr2  = '0;

        // ---- Vector table -------------------------------------------------------------------
        // T1: single ALU write, visible on the port two edges after acceptance, for one cycle.
        add(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
            1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        idle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        idle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        idle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        // T2: reset, then simultaneous requests; req0 wins the first tie.
        idle(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        add(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd0, 5'd0,
            1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        idle(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        // Lone req0 write (addr 2) so the last grant is req0 before the second tie.
        idle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h11, 1'b0, 1'b0);
        add(1'b1, 1'b1, 5'd2, 32'h33, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
            1'b1, 1'b1, 1'b1, 5'd4, 32'h22, 1'b0, 1'b0);
        idle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h22, 1'b0, 1'b0);
        // Second tie (6/7): round-robin now favours req1.
        add(1'b1, 1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0,
            1'b1, 1'b1, 1'b1, 5'd2, 32'h33, 1'b0, 1'b0);
        idle(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd2, 32'h33, 1'b0, 1'b0);
        idle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
        idle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0);
        // T4: load to r0 drains, updates addr3/data3, never raises wr or hazard on r0.
        add(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0,
            1'b1, 1'b1, 1'b0, 5'd6, 32'h66, 1'b0, 1'b0);
        idle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd6, 32'h66, 1'b0, 1'b0);
        idle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        // T5: hazard on r9 for the holding cycle and the write cycle only.
        add(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 5'd9, 5'd8,
            1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        idle(1'b1, 5'd9, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        idle(1'b1, 5'd9, 5'd8, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        idle(1'b1, 5'd9, 5'd8, 1'b1, 1'b1, 1'b0, 5'd9, 32'h99, 1'b0, 1'b0);
        // T6: both entries full, then reset; pending writes are dropped.
        add(1'b1, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 5'd10, 5'd11,
            1'b1, 1'b1, 1'b0, 5'd9, 32'h99, 1'b0, 1'b0);
        idle(1'b0, 5'd10, 5'd11, 1'b0, 1'b1, 1'b0, 5'd9, 32'h99, 1'b1, 1'b1);
        idle(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        idle(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v          = vecs[i];
            rst_n      = v.rst_n;
            req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
            req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
            rd_addr1   = v.r1; rd_addr2  = v.r2;
            #1;
            check($sformatf("v%0d.ready0", i),  64'(req0_ready), 64'(v.rdy0));
            check($sformatf("v%0d.ready1", i),  64'(req1_ready), 64'(v.rdy1));
            check($sformatf("v%0d.wr", i),      64'(wr),         64'(v.wr));
            check($sformatf("v%0d.addr3", i),   64'(addr3),      64'(v.a3));
            check($sformatf("v%0d.data3", i),   64'(data3),      64'(v.d3));
            check($sformatf("v%0d.hazard1", i), 64'(hazard1),    64'(v.hz1));
            check($sformatf("v%0d.hazard2", i), 64'(hazard2),    64'(v.hz2));
        end

        // ---- T3: both requesters saturating -------------------------------------------------
        @(negedge clk);
        rst_n      = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rd_addr1   = '0;   rd_addr2   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        sent0 = 0; sent1 = 0; got0 = 0; got1 = 0;

        for (int cyc = 0; cyc < 64; cyc++) begin
            req0_valid = (sent0 < 16);
            req0_addr  = 5'(sent0 + 1);
            req0_data  = 32'hA000_0000 | 32'(sent0);
            req1_valid = (sent1 < 16);
            req1_addr  = 5'(sent1 + 16);
            req1_data  = 32'hB000_0000 | 32'(sent1);
            #1;
            // After the first joint accept, grants alternate req0, req1, req0, ...
            if (cyc >= 1 && cyc <= 28) begin
                check($sformatf("t3.ready.c%0d", cyc), 64'({req0_ready, req1_ready}),
                      (cyc % 2 == 1) ? 64'h2 : 64'h1);
            end
            if (wr) begin
                if (data3[31:28] == 4'hA) begin
                    check("t3.q0_nonempty", 64'(q0.size() != 0), 64'h1);
                    if (q0.size() != 0) begin
                        exp_item = q0.pop_front();
                        check($sformatf("t3.w0_%0d", got0), 64'({addr3, data3}),
                              64'(exp_item));
                        got0++;
                    end
                end else begin
                    check("t3.q1_nonempty", 64'(q1.size() != 0), 64'h1);
                    if (q1.size() != 0) begin
                        exp_item = q1.pop_front();
                        check($sformatf("t3.w1_%0d", got1), 64'({addr3, data3}),
                              64'(exp_item));
                        got1++;
                    end
                end
            end
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            if (acc0) begin
                q0.push_back({req0_addr, req0_data});
                sent0++;
            end
            if (acc1) begin
                q1.push_back({req1_addr, req1_data});
                sent1++;
            end
            @(negedge clk);
        end
        check("t3.writes0", 64'(got0), 64'd16);
        check("t3.writes1", 64'(got1), 64'd16);
        check("t3.left0", 64'(q0.size()), 64'd0);
        check("t3.left1", 64'(q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
